// File: rtl/pipe_io_debounce.sv
// Input conditioning for the pipeline IO block: synchronises and debounces
// the slide switches and keys[3:1], and keeps sticky per-key press flags
// that software can poll and clear.
//
// Ports:
//   clock          system clock, rising edge
//   resetn         asynchronous active-low reset
//   sw_raw[9:0]    raw slide switches (asynchronous)
//   key_raw[2:0]   raw key[3:1], active-low (asynchronous)
//   key_press_clr  per-key clear for key_press (level)
//   sw_clean       debounced switch levels
//   key_clean      debounced key levels, active-low
//   key_press      sticky press flags, 1 = press accepted since last clear
module pipe_io_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] sw_raw,
    input  logic [2:0] key_raw,
    input  logic [2:0] key_press_clr,
    output logic [9:0] sw_clean,
    output logic [2:0] key_clean,
    output logic [2:0] key_press
);

    localparam int unsigned SW_W  = 10;
    localparam int unsigned KEY_W = 3;
    localparam int unsigned CH_W  = SW_W + KEY_W;

    // Idle level per channel: switches off, keys released (high).
    localparam logic [CH_W-1:0]  RST_VAL  = {{KEY_W{1'b1}}, {SW_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CH_W-1:0]  sync_q [SYNC_STAGES];
    logic [CH_W-1:0]  s_c;
    logic [CH_W-1:0]  clean_q;
    logic [CH_W-1:0]  clean_nxt_c;
    logic [CNT_W-1:0] cnt_q     [CH_W];
    logic [CNT_W-1:0] cnt_nxt_c [CH_W];
    logic [KEY_W-1:0] press_q;
    logic [KEY_W-1:0] press_nxt_c;

    // Multi-stage synchroniser for all channels.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= {key_raw, sw_raw};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_c = sync_q[SYNC_STAGES-1];

    // Debounce: a new level is accepted once it has differed from clean
    // for DEBOUNCE_CYCLES consecutive edges; any return restarts the count.
    always_comb begin
        clean_nxt_c = clean_q;
        for (int unsigned ch = 0; ch < CH_W; ch++) begin
            cnt_nxt_c[ch] = '0;
            if (s_c[ch] != clean_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    clean_nxt_c[ch] = s_c[ch];
                end else begin
                    cnt_nxt_c[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Press flags: a 1->0 acceptance on a key sets its flag and beats a clear.
    always_comb begin
        press_nxt_c = press_q & ~key_press_clr;
        press_nxt_c = press_nxt_c | (clean_q[CH_W-1:SW_W] & ~clean_nxt_c[CH_W-1:SW_W]);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clean_q <= RST_VAL;
            press_q <= '0;
            for (int unsigned ch = 0; ch < CH_W; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            clean_q <= clean_nxt_c;
            press_q <= press_nxt_c;
            for (int unsigned ch = 0; ch < CH_W; ch++) begin
                cnt_q[ch] <= cnt_nxt_c[ch];
            end
        end
    end

    assign sw_clean  = clean_q[SW_W-1:0];
    assign key_clean = clean_q[CH_W-1:SW_W];
    assign key_press = press_q;

endmodule

// File: tb/tb_pipe_io_debounce.sv
// Scoreboard bench for pipe_io_debounce with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, CNT_W=3. The driver queues the hand-computed output
// expected at the next sample point; the monitor samples on every falling
// clock edge and on reset assertion, pops and compares.
module tb_pipe_io_debounce;

    typedef struct packed {
        logic [9:0] sw;
        logic [2:0] key;
        logic [2:0] press;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic [9:0] sw_raw = '0;
    logic [2:0] key_raw = 3'b111;
    logic [2:0] key_press_clr = '0;
    logic [9:0] sw_clean;
    logic [2:0] key_clean;
    logic [2:0] key_press;

    exp_t  sb_q  [$];
    string tag_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    pipe_io_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sw_raw       (sw_raw),
        .key_raw      (key_raw),
        .key_press_clr(key_press_clr),
        .sw_clean     (sw_clean),
        .key_clean    (key_clean),
        .key_press    (key_press)
    );

    always #5 clock = ~clock;

    // Monitor: compare outputs against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clock or negedge resetn);
            #1;
            if (sb_q.size() > 0) begin
                exp_t  e;
                string t;
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                n_cmp++;
                if (sw_clean !== e.sw || key_clean !== e.key || key_press !== e.press) begin
                    n_bad++;
                    $display("FAIL %s: got sw=%h key=%b press=%b, want sw=%h key=%b press=%b",
                             t, sw_clean, key_clean, key_press, e.sw, e.key, e.press);
                end
            end
        end
    end

    task automatic push_exp(input logic [9:0] sw, input logic [2:0] key,
                            input logic [2:0] pr, input string tag);
        exp_t e;
        e.sw = sw; e.key = key; e.press = pr;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance n rising edges, queueing the expected state after each one.
    task automatic exp_edges(input int n, input logic [9:0] sw, input logic [2:0] key,
                             input logic [2:0] pr, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            push_exp(sw, key, pr, tag);
        end
    endtask

    // Assert reset between clock edges (checked immediately), return to idle inputs.
    task automatic do_reset();
        @(negedge clock);
        #2;
        push_exp(10'h000, 3'b111, 3'b000, "async_reset");
        resetn = 1'b0;
        sw_raw = '0;
        key_raw = 3'b111;
        key_press_clr = '0;
        exp_edges(2, 10'h000, 3'b111, 3'b000, "in_reset");
        resetn = 1'b1;
        exp_edges(2, 10'h000, 3'b111, 3'b000, "post_reset_idle");
    endtask

    initial begin
        // 1. Reset with all switches on and all keys pressed.
        sw_raw  = 10'h3FF;
        key_raw = 3'b000;
        push_exp(10'h000, 3'b111, 3'b000, "reset_initial");
        #1 resetn = 1'b0;
        exp_edges(3, 10'h000, 3'b111, 3'b000, "reset_hold");
        resetn = 1'b1;
        exp_edges(5, 10'h000, 3'b111, 3'b000, "reset_release_wait");
        exp_edges(1, 10'h3FF, 3'b000, 3'b111, "reset_release_edge6");
        exp_edges(1, 10'h3FF, 3'b000, 3'b111, "reset_release_hold");

        // 2. Latency of one switch bit.
        do_reset();
        sw_raw[0] = 1'b1;
        exp_edges(5, 10'h000, 3'b111, 3'b000, "latency_wait");
        exp_edges(1, 10'h001, 3'b111, 3'b000, "latency_edge6");
        exp_edges(1, 10'h001, 3'b111, 3'b000, "latency_hold");

        // 3. Bounce on key[1]: 3 low / 2 high never reaches 4 cycles.
        for (int c = 0; c < 40; c++) begin
            key_raw[1] = ((c % 5) < 3) ? 1'b0 : 1'b1;
            exp_edges(1, 10'h001, 3'b111, 3'b000, "bounce");
        end
        key_raw = 3'b101;
        exp_edges(5, 10'h001, 3'b111, 3'b000, "press_wait");
        exp_edges(1, 10'h001, 3'b101, 3'b010, "press_edge6");

        // 4. Release keeps the flag; clear pulse; clear coinciding with press.
        key_raw = 3'b111;
        exp_edges(5, 10'h001, 3'b101, 3'b010, "release_wait");
        exp_edges(1, 10'h001, 3'b111, 3'b010, "release_sticky");
        exp_edges(2, 10'h001, 3'b111, 3'b010, "release_hold");
        key_press_clr = 3'b010;
        exp_edges(1, 10'h001, 3'b111, 3'b000, "clear_pulse");
        key_press_clr = 3'b000;
        exp_edges(1, 10'h001, 3'b111, 3'b000, "clear_hold");
        key_raw = 3'b101;
        exp_edges(5, 10'h001, 3'b111, 3'b000, "repress_wait");
        key_press_clr = 3'b010;
        exp_edges(1, 10'h001, 3'b101, 3'b010, "set_beats_clear");
        key_press_clr = 3'b000;
        exp_edges(2, 10'h001, 3'b101, 3'b010, "set_beats_clear_hold");

        // 5. Reset in the middle of a count on sw[5].
        do_reset();
        sw_raw[5] = 1'b1;
        exp_edges(4, 10'h000, 3'b111, 3'b000, "midcount_wait");
        @(negedge clock);
        #2;
        push_exp(10'h000, 3'b111, 3'b000, "midcount_reset");
        resetn = 1'b0;
        exp_edges(2, 10'h000, 3'b111, 3'b000, "midcount_in_reset");
        resetn = 1'b1;
        exp_edges(5, 10'h000, 3'b111, 3'b000, "midcount_restart");
        exp_edges(1, 10'h020, 3'b111, 3'b000, "midcount_edge6");
        exp_edges(1, 10'h020, 3'b111, 3'b000, "midcount_hold");

        // 6. Independent channels changing together.
        do_reset();
        sw_raw[9]  = 1'b1;
        key_raw[2] = 1'b0;
        exp_edges(5, 10'h000, 3'b111, 3'b000, "indep_wait");
        exp_edges(1, 10'h200, 3'b011, 3'b100, "indep_edge6");
        exp_edges(2, 10'h200, 3'b011, 3'b100, "indep_hold");

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
            @(negedge clock);
        end
        #2;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
